serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 183 ++++++++++++++++++
 tb/tb_serial_subtractor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, one bit per clock, LSB first.
// Optional compare outputs (a_gt_b, a_eq_b, a_lt_b) are enabled by defining SERIAL_SUB_CMP_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_CMP_EN
    ,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned LAST  = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_bw;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [WIDTH-1:0]   w_res_nxt;
    logic               w_bw_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   w_diff_nxt;
    logic               w_borrow_nxt;

    logic               w_d;
    logic               w_bw_bit;
    logic [WIDTH-1:0]   w_res_shift;
    logic               w_last;

`ifdef SERIAL_SUB_CMP_EN
    logic r_gt;
    logic r_eq;
    logic r_lt;
    logic w_gt_nxt;
    logic w_eq_nxt;
    logic w_lt_nxt;
`endif

    // One full-subtractor slice on the current LSBs
    always_comb begin
        w_d         = r_a[0] ^ r_b[0] ^ r_bw;
        w_bw_bit    = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bw);
        w_res_shift = {w_d, r_res[WIDTH-1:1]};
        w_last      = (r_cnt == CNT_W'(LAST));
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_res_nxt    = r_res;
        w_bw_nxt     = r_bw;
        w_cnt_nxt    = r_cnt;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_diff_nxt   = r_diff;
        w_borrow_nxt = r_borrow;
`ifdef SERIAL_SUB_CMP_EN
        w_gt_nxt     = r_gt;
        w_eq_nxt     = r_eq;
        w_lt_nxt     = r_lt;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_res_nxt   = '0;
                    w_bw_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_a_nxt   = {1'b0, r_a[WIDTH-1:1]};
                w_b_nxt   = {1'b0, r_b[WIDTH-1:1]};
                w_res_nxt = w_res_shift;
                w_bw_nxt  = w_bw_bit;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_state_nxt  = S_DONE;
                    w_diff_nxt   = w_res_shift;
                    w_borrow_nxt = w_bw_bit;
`ifdef SERIAL_SUB_CMP_EN
                    w_lt_nxt     = w_bw_bit;
                    w_eq_nxt     = (w_res_shift == '0) && !w_bw_bit;
                    w_gt_nxt     = !w_bw_bit && (w_res_shift != '0);
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_RUN);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_bw     <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_res    <= w_res_nxt;
            r_bw     <= w_bw_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_diff   <= w_diff_nxt;
            r_borrow <= w_borrow_nxt;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

`ifdef SERIAL_SUB_CMP_EN
    // Compare flags follow the result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt <= 1'b0;
            r_eq <= 1'b0;
            r_lt <= 1'b0;
        end else begin
            r_gt <= w_gt_nxt;
            r_eq <= w_eq_nxt;
            r_lt <= w_lt_nxt;
        end
    end

    assign a_gt_b = r_gt;
    assign a_eq_b = r_eq;
    assign a_lt_b = r_lt;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); compare checks only with SERIAL_SUB_CMP_EN.
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_CMP_EN
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;
`endif

    int n_cmp;
    int n_err;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_CMP_EN
        ,
        .a_gt_b     (a_gt_b),
        .a_eq_b     (a_eq_b),
        .a_lt_b     (a_lt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'd0);
        check({tag, "_bw"},   32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_CMP_EN
        check({tag, "_cmp"},  32'({a_gt_b, a_eq_b, a_lt_b}), 32'd0);
`endif
    endtask

    // Runs one operation from IDLE; cmp is {gt,eq,lt}. Operands are scrambled during RUN.
    task automatic do_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                         input logic [7:0] exp_diff, input logic exp_bw,
                         input logic [2:0] exp_cmp, input logic hold_start);
        int lat;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        tick();
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
        if (!hold_start) start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (busy && done) check({tag, "_busy_and_done"}, 32'd1, 32'd0);
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        check({tag, "_bw"}, 32'(borrow_out), 32'(exp_bw));
`ifdef SERIAL_SUB_CMP_EN
        check({tag, "_cmp"}, 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(exp_cmp));
`else
        if (exp_cmp == 3'b111) check({tag, "_cmp_arg"}, 32'(exp_cmp), 32'd0);
`endif
        tick();
        check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n_done;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check_cleared("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_cleared("idle_after_rst");

        // Tests 1-3b
        do_op("t1",  8'h05, 8'h03, 8'h02, 1'b0, 3'b100, 1'b0);
        a = 8'hAA;
        b = 8'h11;
        repeat (3) tick();
        check("idle_hold_diff", 32'(diff), 32'h02);
        check("idle_hold_done", 32'(done), 32'd0);
        do_op("t2",  8'h03, 8'h05, 8'hFE, 1'b1, 3'b001, 1'b0);
        do_op("t3",  8'hFF, 8'hFF, 8'h00, 1'b0, 3'b010, 1'b0);
        do_op("t3b", 8'h00, 8'h01, 8'hFF, 1'b1, 3'b001, 1'b0);

        // Test 4: start held, operands changed mid-run
        do_op("t4a", 8'h10, 8'h01, 8'h0F, 1'b0, 3'b100, 1'b1);
        do_op("t4b", 8'h40, 8'h50, 8'hF0, 1'b1, 3'b001, 1'b1);
        start  = 1'b0;
        n_done = 0;
        repeat (12) begin
            tick();
            if (done) n_done++;
        end
        check("t4_no_extra_done", 32'(n_done), 32'd0);

        // Test 5: asynchronous reset at RUN bit 4
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t5_busy_before_rst", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_cleared("t5_in_rst");
        #2;
        rst_n = 1'b1;
        n_done = 0;
        repeat (12) begin
            tick();
            if (done) n_done++;
        end
        check("t5_no_done", 32'(n_done), 32'd0);
        check_cleared("t5_after_rst");
        do_op("t5_next", 8'h80, 8'h01, 8'h7F, 1'b0, 3'b100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
